// File: rtl/grid_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter_pkg
// Description : Shared op codes, FSM states and grid constants for the
//               grid occupancy RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_access_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_CLAIM = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_CAPT     = 3'd2,
        ST_CLAIM_WR = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    function automatic int grid_cells(input int n);
        return n * n;
    endfunction

    localparam int c_GRID_N     = 8;
    localparam int c_GRID_CELLS = grid_cells(c_GRID_N);
    localparam int c_EMPTY      = -1;

    // The reserved encoding behaves exactly like a plain read.
    function automatic op_e decode_op(input logic [1:0] raw);
        return (raw == 2'd3) ? OP_READ : op_e'(raw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter_if
// Description : Requester handshake and grid RAM bus of the grid arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface grid_access_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [2*N_REQ-1:0]      req_op;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_ok;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    // slave: the arbiter; master: the engines plus the RAM around it
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_ok,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_ok,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/grid_access_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter_rr_pick
// Description : Combinational round-robin first-set-bit search from a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_access_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_found
);
    logic             w_hi_found;
    logic             w_lo_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Bits at or above the pointer win over the wrapped-around lower bits.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i] && (i >= int'(i_ptr)) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IDX_W'(i);
            end
            if (i_req[i] && (i < int'(i_ptr)) && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDX_W'(i);
            end
        end
        o_found = w_hi_found | w_lo_found;
        o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    end

endmodule
`default_nettype wire

// File: rtl/grid_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter
// Description : Round-robin arbiter sharing one grid occupancy RAM between
//               placement engines, with read, write and atomic claim.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_access_arbiter
    import grid_access_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int GRID_CELLS = c_GRID_CELLS,
    parameter int EMPTY      = c_EMPTY
) (
    input  wire logic            clk,
    input  wire logic            reset,
    grid_access_arbiter_if.slave bus,
    output logic                 busy,
    output logic [31:0]          claim_fail_cnt
);
    localparam int                c_IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W:0]   c_CELLS      = (ADDR_W + 1)'(GRID_CELLS);
    localparam logic [DATA_W-1:0] c_EMPTY_WORD = DATA_W'(EMPTY);

    logic [1:0]        w_op_raw [N_REQ];
    logic [ADDR_W-1:0] w_addr   [N_REQ];
    logic [DATA_W-1:0] w_wdata  [N_REQ];

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_op_raw[g] = bus.req_op[2*g +: 2];
            assign w_addr[g]   = bus.req_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata[g]  = bus.req_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    state_e             r_state;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_owner;
    op_e                r_op;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_legal;
    logic [N_REQ-1:0]   r_req_ready;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_ok;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_busy;
    logic [31:0]        r_claim_fail_cnt;

    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_pick_found;
    op_e                w_pick_op;
    logic               w_pick_legal;
    logic [c_IDX_W-1:0] w_next_ptr;
    logic [N_REQ-1:0]   w_owner_onehot;
    logic               w_claim_empty;

    grid_access_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_pick_op      = decode_op(w_op_raw[w_pick_idx]);
    assign w_pick_legal   = ({1'b0, w_addr[w_pick_idx]} < c_CELLS);
    assign w_next_ptr     = (w_pick_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + c_IDX_W'(1);
    assign w_owner_onehot = N_REQ'(1) << r_owner;
    assign w_claim_empty  = ($signed(bus.mem_rdata) == $signed(c_EMPTY_WORD));

    // Outputs are registered together with the state they belong to, so each
    // branch loads the values that must appear during the state it enters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_rr_ptr         <= '0;
            r_owner          <= '0;
            r_op             <= OP_READ;
            r_wdata          <= '0;
            r_legal          <= 1'b0;
            r_req_ready      <= '0;
            r_rsp_valid      <= '0;
            r_rsp_rdata      <= '0;
            r_rsp_ok         <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_busy           <= 1'b0;
            r_claim_fail_cnt <= '0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_owner     <= w_pick_idx;
                        r_op        <= w_pick_op;
                        r_wdata     <= w_wdata[w_pick_idx];
                        r_legal     <= w_pick_legal;
                        r_rr_ptr    <= w_next_ptr;
                        r_req_ready <= N_REQ'(1) << w_pick_idx;
                        r_mem_addr  <= w_addr[w_pick_idx];
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                        if (w_pick_legal) begin
                            if (w_pick_op == OP_WRITE) begin
                                r_mem_write <= 1'b1;
                                r_mem_wdata <= w_wdata[w_pick_idx];
                            end else begin
                                r_mem_read  <= 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!r_legal || (r_op == OP_WRITE)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_ok    <= r_legal;
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= ST_RESP;
                        if (!r_legal && (r_op == OP_CLAIM)) begin
                            r_claim_fail_cnt <= r_claim_fail_cnt + 32'd1;
                        end
                    end else begin
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    r_rsp_rdata <= bus.mem_rdata;
                    if ((r_op == OP_CLAIM) && w_claim_empty) begin
                        // mem_addr still holds the claimed cell from ISSUE
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= r_wdata;
                        r_state     <= ST_CLAIM_WR;
                    end else begin
                        r_rsp_ok    <= (r_op != OP_CLAIM);
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= ST_RESP;
                        if (r_op == OP_CLAIM) begin
                            r_claim_fail_cnt <= r_claim_fail_cnt + 32'd1;
                        end
                    end
                end
                ST_CLAIM_WR: begin
                    r_rsp_ok    <= 1'b1;
                    r_rsp_valid <= w_owner_onehot;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_ok     = r_rsp_ok;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign busy           = r_busy;
    assign claim_fail_cnt = r_claim_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_grid_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_access_arbiter
// Description : Randomized self-checking bench for grid_access_arbiter with a
//               transaction-level reference model and a behavioural grid RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_access_arbiter;
    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int CELLS = 64;
    localparam int BIG   = 1 << 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [31:0] claim_fail_cnt;

    grid_access_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    grid_access_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .GRID_CELLS(CELLS), .EMPTY(-1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .busy           (busy),
        .claim_fail_cnt (claim_fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port grid RAM with one-cycle registered read
    logic [31:0] ram [CELLS];
    always @(posedge clk) begin
        if (bus.mem_write && (bus.mem_addr < AW'(CELLS))) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
        if (bus.mem_read)
            bus.mem_rdata <= (bus.mem_addr < AW'(CELLS)) ? ram[bus.mem_addr[5:0]] : 32'hDEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: grid contents, pending requests and the one op in flight
    logic [31:0]   golden [CELLS];
    bit   [N-1:0]  pending;
    logic [1:0]    p_op   [N];
    logic [AW-1:0] p_addr [N];
    logic [31:0]   p_data [N];
    int            m_rr, m_free, m_fail;
    int            exp_ready_cycle, exp_rsp_cycle, exp_rd_cycle, exp_wr_cycle, exp_owner;
    logic [31:0]   exp_rdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    bit            exp_ok, exp_chk_rdata;

    task automatic clear_expect();
        exp_ready_cycle = -1;
        exp_rsp_cycle   = -1;
        exp_rd_cycle    = -1;
        exp_wr_cycle    = -1;
    endtask

    task automatic post(input int r, input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d);
        pending[r] = 1'b1;
        p_op[r]    = op;
        p_addr[r]  = a;
        p_data[r]  = d;
    endtask

    task automatic drive();
        bus.req_valid = pending;
        for (int i = 0; i < N; i++) begin
            bus.req_op[2*i +: 2]     = p_op[i];
            bus.req_addr[i*AW +: AW] = p_addr[i];
            bus.req_wdata[i*DW +: DW] = p_data[i];
        end
    endtask

    task automatic model_pick();
        int          w;
        int          lat;
        logic [1:0]  op;
        logic [31:0] prev;
        if (cyc < m_free || pending == '0) return;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int r;
            r = (m_rr + i) % N;
            if (w < 0 && pending[r]) w = r;
        end
        op = (p_op[w] == 2'd3) ? 2'd0 : p_op[w];
        clear_expect();
        exp_owner     = w;
        exp_addr      = p_addr[w];
        exp_wdata     = p_data[w];
        exp_chk_rdata = 1'b1;
        if (p_addr[w] >= AW'(CELLS)) begin
            lat = 2; exp_ok = 1'b0; exp_rdata = 32'd0;
            if (op == 2'd2) m_fail++;
        end else if (op == 2'd1) begin
            lat = 2; exp_ok = 1'b1; exp_chk_rdata = 1'b0;
            golden[p_addr[w]] = p_data[w];
            exp_wr_cycle = cyc + 1;
        end else if (op == 2'd0) begin
            lat = 3; exp_ok = 1'b1; exp_rdata = golden[p_addr[w]];
            exp_rd_cycle = cyc + 1;
        end else begin
            prev = golden[p_addr[w]];
            exp_rdata = prev;
            exp_rd_cycle = cyc + 1;
            if (prev == 32'hFFFF_FFFF) begin
                lat = 4; exp_ok = 1'b1;
                golden[p_addr[w]] = p_data[w];
                exp_wr_cycle = cyc + 3;
            end else begin
                lat = 3; exp_ok = 1'b0; m_fail++;
            end
        end
        exp_ready_cycle = cyc + 1;
        exp_rsp_cycle   = cyc + lat;
        m_free          = cyc + lat + 1;
        m_rr            = (w + 1) % N;
        pending[w]      = 1'b0;
    endtask

    task automatic cycle_checks();
        logic [N-1:0] e_ready, e_rsp;
        e_ready = (cyc == exp_ready_cycle) ? (N'(1) << exp_owner) : '0;
        e_rsp   = (cyc == exp_rsp_cycle)   ? (N'(1) << exp_owner) : '0;
        check_eq("req_ready", bus.req_ready, e_ready);
        check_eq("rsp_valid", bus.rsp_valid, e_rsp);
        check_eq("busy", busy, (exp_ready_cycle >= 0) && (cyc >= exp_ready_cycle) && (cyc <= exp_rsp_cycle));
        check_eq("mem_rw", {bus.mem_read, bus.mem_write}, {cyc == exp_rd_cycle, cyc == exp_wr_cycle});
        if (bus.mem_read || bus.mem_write) check_eq("mem_addr", bus.mem_addr, exp_addr);
        if (bus.mem_write) check_eq("mem_wdata", bus.mem_wdata, exp_wdata);
        if (cyc == exp_rsp_cycle) begin
            check_eq("rsp_ok", bus.rsp_ok, exp_ok);
            if (exp_chk_rdata) check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check_eq("claim_fail_cnt", claim_fail_cnt, m_fail);
        end
    endtask

    task automatic gen();
        for (int r = 0; r < N; r++) begin
            if (!pending[r] && !bus.req_ready[r] && $urandom_range(0, 2) == 0) begin
                post(r, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) == 0) ? AW'($urandom_range(64, 4095)) : AW'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1000)));
            end
        end
    endtask

    task automatic step(input bit new_reqs);
        @(negedge clk);
        cycle_checks();
        if (reset) begin
            check_eq("rst_claim_fail_cnt", claim_fail_cnt, 32'd0);
            check_eq("rst_rsp_ok", bus.rsp_ok, 1'b0);
            check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            check_eq("rst_mem_addr", bus.mem_addr, 12'd0);
            check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
            reset  = 1'b0;
            m_free = cyc;
        end
        if (new_reqs) gen();
        drive();
        model_pick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pending != '0 || cyc < m_free) && n < 200) begin
            step(1'b0);
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        reset   = 1'b1;
        pending = '0;
        m_rr    = 0;
        m_fail  = 0;
        m_free  = BIG;
        clear_expect();
        exp_owner = 0;
        for (int i = 0; i < N; i++) post(i, 2'd0, '0, '0);
        pending = '0;
        for (int i = 0; i < CELLS; i++) begin
            ram[i]    = 32'hFFFF_FFFF;
            golden[i] = 32'hFFFF_FFFF;
        end
        drive();
        repeat (2) @(negedge clk);
        step(1'b0);

        post(0, 2'd0, 12'd5, 32'd0);          drain();
        post(1, 2'd2, 12'd10, 32'd7);         drain();
        post(3, 2'd0, 12'd10, 32'd0);         drain();
        post(0, 2'd2, 12'd20, 32'd3);
        post(2, 2'd2, 12'd20, 32'd9);         drain();
        for (int i = 0; i < N; i++) post(i, 2'd0, 12'(i + 1), 32'd0);
        drain();
        post(1, 2'd1, 12'd64, 32'd123);       drain();
        post(2, 2'd2, 12'd100, 32'd1);        drain();
        post(3, 2'd3, 12'd20, 32'd0);         drain();

        // Abort a claim by resetting during its capture cycle
        saved = golden[30];
        post(1, 2'd2, 12'd30, 32'd5);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        reset      = 1'b1;
        golden[30] = saved;
        m_fail     = 0;
        m_rr       = 0;
        m_free     = BIG;
        clear_expect();
        step(1'b0);
        post(2, 2'd0, 12'd30, 32'd0);         drain();

        for (int k = 0; k < 2000; k++) step(1'b1);
        drain();

        for (int i = 0; i < CELLS; i++) check_eq("ram_final", ram[i], golden[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
